// File: rtl/dmem_arb_pkg.sv
// Shared widths, owner codes and helpers for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int HBIT_ADDR = 47;
  localparam int HBIT_DATA = 23;

  // Owner encoding carried in the read tag.
  localparam logic ARB_OWN_P = 1'b0;
  localparam logic ARB_OWN_A = 1'b1;

  // One access as seen by the memory side.
  typedef struct packed {
    logic                 we;
    logic                 is48;
    logic [HBIT_ADDR:0]   addr;
    logic [HBIT_ADDR:0]   wdata;
  } req_t;

  // Outstanding read: captured at the grant edge, consumed one cycle later.
  typedef struct packed {
    logic vld;
    logic owner;
    logic is48;
  } tag_t;

  // Reassemble a response from the two lanes; only the low lane bits are data.
  function automatic logic [HBIT_ADDR:0] merge_rd(input logic               is48,
                                                  input logic [HBIT_ADDR:0] r0,
                                                  input logic [HBIT_ADDR:0] r1);
    logic [HBIT_ADDR:0] v;
    if (is48) v = {r0[HBIT_DATA:0], r1[HBIT_DATA:0]};
    else      v = {{(HBIT_ADDR-HBIT_DATA){1'b0}}, r0[HBIT_DATA:0]};
    return v;
  endfunction

endpackage

// File: rtl/dmem_arb_starve_cnt.sv
// Saturating refusal counter for the aux requester; sat_o forces a grant.
module dmem_arb_starve_cnt #(
  parameter int MAX = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic sat_o
);

  localparam int W = (MAX < 1) ? 1 : $clog2(MAX + 1);
  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] cnt_q, cnt_d;

  // Clear wins over increment; hold once saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                        cnt_d = '0;
    else if (inc_i && cnt_q != MAX_V) cnt_d = cnt_q + 1'b1;
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign sat_o = (cnt_q == MAX_V);

endmodule

// File: rtl/dmem_arb.sv
// Two-requester arbiter for the dual-lane data memory: pipeline (P) has
// priority, aux (A) is force-granted after STARVE_MAX refusals. 48-bit
// accesses span lane 0 (addr) and lane 1 (addr+1); read data is routed back
// to its issuer one cycle after the grant.
module dmem_arb
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic                 iw_clk,
  input  logic                 iw_rst,
  // pipeline requester
  input  logic                 iw_p_req,
  input  logic                 iw_p_we,
  input  logic                 iw_p_is48,
  input  logic [HBIT_ADDR:0]   iw_p_addr,
  input  logic [HBIT_ADDR:0]   iw_p_wdata,
  output logic                 ow_p_stall,
  output logic                 ow_p_rvalid,
  output logic [HBIT_ADDR:0]   ow_p_rdata,
  // aux requester
  input  logic                 iw_a_valid,
  output logic                 ow_a_ready,
  input  logic                 iw_a_we,
  input  logic                 iw_a_is48,
  input  logic [HBIT_ADDR:0]   iw_a_addr,
  input  logic [HBIT_ADDR:0]   iw_a_wdata,
  output logic                 ow_a_rvalid,
  output logic [HBIT_ADDR:0]   ow_a_rdata,
  // memory lanes
  output logic                 ow_mem_we0,
  output logic                 ow_mem_we1,
  output logic [HBIT_ADDR:0]   ow_mem_addr0,
  output logic [HBIT_ADDR:0]   ow_mem_addr1,
  output logic [HBIT_ADDR:0]   ow_mem_wdata0,
  output logic [HBIT_ADDR:0]   ow_mem_wdata1,
  output logic                 ow_mem_is48,
  input  logic [HBIT_ADDR:0]   iw_mem_rdata0,
  input  logic [HBIT_ADDR:0]   iw_mem_rdata1
);

  localparam int PADW = HBIT_ADDR - HBIT_DATA;

  logic  sat;
  logic  gnt_a, gnt_p, gnt;
  req_t  p_req, a_req, sel;
  tag_t  tag_q, tag_d;
  logic  [HBIT_ADDR:0] rd;

  assign p_req = '{we: iw_p_we, is48: iw_p_is48, addr: iw_p_addr, wdata: iw_p_wdata};
  assign a_req = '{we: iw_a_we, is48: iw_a_is48, addr: iw_a_addr, wdata: iw_a_wdata};

  // Grant is purely combinational in the request cycle; nothing is granted in reset.
  assign gnt_a = !iw_rst && iw_a_valid && (!iw_p_req || sat);
  assign gnt_p = !iw_rst && iw_p_req && !gnt_a;
  assign gnt   = gnt_a || gnt_p;
  assign sel   = gnt_a ? a_req : p_req;

  assign ow_a_ready = gnt_a;
  assign ow_p_stall = gnt_a && iw_p_req;

  // Refusals of a waiting A; any A grant or idle A restarts the count.
  dmem_arb_starve_cnt #(.MAX(STARVE_MAX)) u_starve (
    .clk_i (iw_clk),
    .rst_i (iw_rst),
    .inc_i (iw_a_valid && !gnt_a),
    .clr_i (gnt_a || !iw_a_valid),
    .sat_o (sat)
  );

  // Lane split of the granted access; memory ports idle at zero otherwise.
  always_comb begin
    ow_mem_we0    = 1'b0;
    ow_mem_we1    = 1'b0;
    ow_mem_addr0  = '0;
    ow_mem_addr1  = '0;
    ow_mem_wdata0 = '0;
    ow_mem_wdata1 = '0;
    ow_mem_is48   = 1'b0;
    if (gnt) begin
      ow_mem_we0    = sel.we;
      ow_mem_we1    = sel.we && sel.is48;
      ow_mem_addr0  = sel.addr;
      ow_mem_addr1  = sel.addr + 1'b1;   // wraps to 0 at the top address
      ow_mem_wdata0 = sel.is48 ? {{PADW{1'b0}}, sel.wdata[HBIT_ADDR:HBIT_DATA+1]}
                               : {{PADW{1'b0}}, sel.wdata[HBIT_DATA:0]};
      ow_mem_wdata1 = {{PADW{1'b0}}, sel.wdata[HBIT_DATA:0]};
      ow_mem_is48   = sel.is48;
    end
  end

  // Tag of a granted read, consumed by the response next cycle.
  always_comb begin
    tag_d       = '0;
    tag_d.vld   = gnt && !sel.we;
    tag_d.owner = gnt_a ? ARB_OWN_A : ARB_OWN_P;
    tag_d.is48  = sel.is48;
  end

  // Tag register; reset drops any in-flight response.
  always_ff @(posedge iw_clk) begin
    if (iw_rst) tag_q <= '0;
    else        tag_q <= tag_d;
  end

  // Response routing: only the owner sees valid data, the other side reads zero.
  always_comb begin
    rd          = merge_rd(tag_q.is48, iw_mem_rdata0, iw_mem_rdata1);
    ow_p_rvalid = !iw_rst && tag_q.vld && (tag_q.owner == ARB_OWN_P);
    ow_a_rvalid = !iw_rst && tag_q.vld && (tag_q.owner == ARB_OWN_A);
    ow_p_rdata  = ow_p_rvalid ? rd : '0;
    ow_a_rdata  = ow_a_rvalid ? rd : '0;
  end

endmodule

// File: tb/tb_dmem_arb.sv
// Bench for dmem_arb: a small lane memory model, a reference memory updated
// from the stimulus, table-driven grant/lane checks and a response scoreboard.
module tb_dmem_arb;
  import dmem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        p_req, p_we, p_is48, a_valid, a_we, a_is48;
  logic [47:0] p_addr, p_wdata, a_addr, a_wdata;
  logic        p_stall, p_rvalid, a_ready, a_rvalid;
  logic [47:0] p_rdata, a_rdata;
  logic        we0, we1, m_is48;
  logic [47:0] addr0, addr1, wdata0, wdata1, rd0_q, rd1_q;

  always #5 clk = ~clk;

  dmem_arb #(.STARVE_MAX(4)) dut (
    .iw_clk(clk), .iw_rst(rst),
    .iw_p_req(p_req), .iw_p_we(p_we), .iw_p_is48(p_is48),
    .iw_p_addr(p_addr), .iw_p_wdata(p_wdata),
    .ow_p_stall(p_stall), .ow_p_rvalid(p_rvalid), .ow_p_rdata(p_rdata),
    .iw_a_valid(a_valid), .ow_a_ready(a_ready), .iw_a_we(a_we), .iw_a_is48(a_is48),
    .iw_a_addr(a_addr), .iw_a_wdata(a_wdata),
    .ow_a_rvalid(a_rvalid), .ow_a_rdata(a_rdata),
    .ow_mem_we0(we0), .ow_mem_we1(we1), .ow_mem_addr0(addr0), .ow_mem_addr1(addr1),
    .ow_mem_wdata0(wdata0), .ow_mem_wdata1(wdata1), .ow_mem_is48(m_is48),
    .iw_mem_rdata0(rd0_q), .iw_mem_rdata1(rd1_q)
  );

  // Lane memory: addresses used by the bench are distinct in their low 6 bits.
  // Upper rdata bits carry junk so that masking in the DUT is exercised.
  logic [23:0] mem [64];
  logic        mem_clr;
  always @(posedge clk) begin
    rd0_q <= {24'hA5A5A5, mem[addr0[5:0]]};
    rd1_q <= {24'h5A5A5A, mem[addr1[5:0]]};
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else begin
      if (we0) mem[addr0[5:0]] <= wdata0[23:0];
      if (we1) mem[addr1[5:0]] <= wdata1[23:0];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_err = 0;
  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference memory written from the stimulus intent, not from the DUT.
  logic [23:0] ref_mem [64];
  function automatic logic [47:0] ref_rd(input logic is48, input logic [47:0] a);
    logic [47:0] a1;
    a1 = a + 48'd1;
    return is48 ? {ref_mem[a[5:0]], ref_mem[a1[5:0]]} : {24'h0, ref_mem[a[5:0]]};
  endfunction

  typedef struct {
    logic        own_a;
    logic [47:0] data;
    int          due;
  } exp_t;
  exp_t sb[$];
  bit   run = 0;

  // Response checker: exactly one expected response per due cycle, else silence.
  always @(negedge clk) begin
    if (run) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        exp_t e;
        e = sb.pop_front();
        chk(e.own_a ? "a_rvalid" : "p_rvalid", e.own_a ? a_rvalid : p_rvalid, 1);
        chk(e.own_a ? "a_rdata"  : "p_rdata",  e.own_a ? a_rdata  : p_rdata,  e.data);
        chk(e.own_a ? "p_rvalid other" : "a_rvalid other", e.own_a ? p_rvalid : a_rvalid, 0);
        chk(e.own_a ? "p_rdata other"  : "a_rdata other",  e.own_a ? p_rdata  : a_rdata,  0);
      end else begin
        chk("p_rvalid idle", p_rvalid, 0);
        chk("a_rvalid idle", a_rvalid, 0);
      end
    end
  end

  typedef struct {
    logic        pr, pw, p48;
    logic [47:0] pa, pd;
    logic        av, aw, a48;
    logic [47:0] aa, ad;
    logic        e_stall, e_ready, e_we0, e_we1;
  } vec_t;

  function automatic vec_t mk(input logic pr, pw, p48, input logic [47:0] pa, pd,
                              input logic av, aw, a48, input logic [47:0] aa, ad,
                              input logic es, er, ew0, ew1);
    vec_t v;
    v.pr = pr; v.pw = pw; v.p48 = p48; v.pa = pa; v.pd = pd;
    v.av = av; v.aw = aw; v.a48 = a48; v.aa = aa; v.ad = ad;
    v.e_stall = es; v.e_ready = er; v.e_we0 = ew0; v.e_we1 = ew1;
    return v;
  endfunction

  // Drive one cycle, predict the granted access and check the memory side.
  task automatic apply(input vec_t v, input string nm);
    logic        g, gw, g48;
    logic [47:0] ga, gd, a1;
    @(posedge clk); #1;
    rst = 1'b0;
    p_req = v.pr; p_we = v.pw; p_is48 = v.p48; p_addr = v.pa; p_wdata = v.pd;
    a_valid = v.av; a_we = v.aw; a_is48 = v.a48; a_addr = v.aa; a_wdata = v.ad;
    g  = v.e_ready || (v.pr && !v.e_stall);
    gw = v.e_ready ? v.aw  : v.pw;
    g48 = v.e_ready ? v.a48 : v.p48;
    ga = v.e_ready ? v.aa  : v.pa;
    gd = v.e_ready ? v.ad  : v.pd;
    a1 = ga + 48'd1;
    if (g) begin
      if (gw) begin
        ref_mem[ga[5:0]] = g48 ? gd[47:24] : gd[23:0];
        if (g48) ref_mem[a1[5:0]] = gd[23:0];
      end else begin
        exp_t e;
        e.own_a = v.e_ready; e.data = ref_rd(g48, ga); e.due = cyc + 1;
        sb.push_back(e);
      end
    end
    @(negedge clk);
    chk({nm, " stall"}, p_stall, v.e_stall);
    chk({nm, " ready"}, a_ready, v.e_ready);
    chk({nm, " we0"},   we0,     v.e_we0);
    chk({nm, " we1"},   we1,     v.e_we1);
    if (g) begin
      chk({nm, " addr0"}, addr0, ga);
      chk({nm, " addr1"}, addr1, a1);
      chk({nm, " is48"},  m_is48, g48);
      if (gw) chk({nm, " wdata0"}, wdata0, {24'h0, g48 ? gd[47:24] : gd[23:0]});
      if (gw && g48) chk({nm, " wdata1"}, wdata1, {24'h0, gd[23:0]});
    end
  endtask

  // One reset cycle with live requests: everything must read zero.
  task automatic rst_cycle(input string nm);
    @(posedge clk); #1;
    rst = 1'b1;
    p_req = 1'b1; p_we = 1'b1; p_is48 = 1'b1; p_addr = 48'd12; p_wdata = 48'hFFFF_FFFF_FFFF;
    a_valid = 1'b1; a_we = 1'b1; a_is48 = 1'b1; a_addr = 48'd5; a_wdata = 48'hFFFF_FFFF_FFFF;
    sb.delete();
    @(negedge clk);
    chk({nm, " stall"}, p_stall, 0);
    chk({nm, " ready"}, a_ready, 0);
    chk({nm, " we0"}, we0, 0);
    chk({nm, " we1"}, we1, 0);
    chk({nm, " p_rvalid"}, p_rvalid, 0);
    chk({nm, " a_rvalid"}, a_rvalid, 0);
    chk({nm, " p_rdata"}, p_rdata, 0);
    chk({nm, " a_rdata"}, a_rdata, 0);
  endtask

  localparam logic [47:0] TOP = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] Z   = 48'h0;

  vec_t tbl[$];
  vec_t sv;

  initial begin
    rst = 1'b1; mem_clr = 1'b1;
    p_req = 0; p_we = 0; p_is48 = 0; p_addr = Z; p_wdata = Z;
    a_valid = 0; a_we = 0; a_is48 = 0; a_addr = Z; a_wdata = Z;
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    repeat (2) @(posedge clk);
    #1 mem_clr = 1'b0;
    rst_cycle("reset");
    run = 1;

    //            pr pw p48 addr    wdata                 av aw a48 addr   wdata          st rd w0 w1
    tbl.push_back(mk(0, 0, 0, Z,      Z,                    0, 0, 0, Z,     Z,             0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 48'd12, 48'h123456_ABCDEF,    0, 0, 0, Z,     Z,             0, 0, 1, 1));
    tbl.push_back(mk(1, 1, 0, 48'd5,  48'h000000_00BEEF,    0, 0, 0, Z,     Z,             0, 0, 1, 0));
    tbl.push_back(mk(1, 1, 0, 48'd20, 48'h000000_000111,    0, 0, 0, Z,     Z,             0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 1, 48'd12, Z,                    0, 0, 0, Z,     Z,             0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, Z,      Z,                    1, 0, 0, 48'd5, Z,             0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 1, 48'd12, Z,                    0, 0, 0, Z,     Z,             0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, Z,      Z,                    1, 0, 0, 48'd5, Z,             0, 1, 0, 0));
    tbl.push_back(mk(1, 1, 1, TOP,    48'hAAAAAA_555555,    0, 0, 0, Z,     Z,             0, 0, 1, 1));
    tbl.push_back(mk(1, 0, 0, Z,      Z,                    0, 0, 0, Z,     Z,             0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, Z,      Z,                    1, 0, 1, TOP,   Z,             0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 48'd20, Z,                    1, 1, 0, 48'd20, 48'h777,      0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, Z,      Z,                    1, 1, 0, 48'd20, 48'h777,      0, 1, 1, 0));
    tbl.push_back(mk(1, 0, 0, 48'd20, Z,                    0, 0, 0, Z,     Z,             0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, Z,      Z,                    1, 1, 1, 48'd40, 48'hC0FFEE_D00D11, 0, 1, 1, 1));
    tbl.push_back(mk(1, 0, 1, 48'd40, Z,                    0, 0, 0, Z,     Z,             0, 0, 0, 0));
    foreach (tbl[i]) apply(tbl[i], $sformatf("v%0d", i));

    // Starvation: A refused four cycles, forced on the fifth with a one-cycle
    // P stall; the second round shows the counter restarted from zero.
    for (int r = 0; r < 2; r++) begin
      for (int k = 1; k <= 5; k++) begin
        sv = mk(1, 0, 1, 48'd12, Z, 1, 0, 0, 48'd5, Z, k == 5, k == 5, 0, 0);
        apply(sv, $sformatf("starve r%0d c%0d", r, k));
      end
      sv = mk(1, 0, 1, 48'd12, Z, 0, 0, 0, Z, Z, 0, 0, 0, 0);
      apply(sv, $sformatf("starve r%0d after", r));
    end

    // Reset the cycle after a P read grant: response dropped, then resume.
    sv = mk(1, 0, 1, 48'd12, Z, 0, 0, 0, Z, Z, 0, 0, 0, 0);
    apply(sv, "pre-reset read");
    rst_cycle("mid-read reset");
    apply(sv, "post-reset read");
    sv = mk(0, 0, 0, Z, Z, 0, 0, 0, Z, Z, 0, 0, 0, 0);
    apply(sv, "drain");
    apply(sv, "drain2");

    if (sb.size() != 0) chk("scoreboard empty", 48'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
